// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-side front end.
package regfile_pkg;

    localparam int DATA_WIDTH    = 64;
    localparam int ADDRESS_WIDTH = 5;
    localparam int REGISTER_SIZE = 2 ** ADDRESS_WIDTH;
    localparam int FIFO_DEPTH    = 4;

    typedef logic [ADDRESS_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0]    reg_data_t;

    // One queued register-file write.
    typedef struct packed {
        reg_addr_t wa;
        reg_data_t wd;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writer_wb_fifo.sv
// Write-back queue: up to two pushes (slot order push0 then push1) and one pop
// per cycle. Per-slot valid/address are exported so the top can build the
// pending mask without walking pointers.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                                clk,
    input  logic                                rst_ni,
    input  logic                                push0_i,
    input  wb_entry_t                           push0_entry_i,
    input  logic                                push1_i,
    input  wb_entry_t                           push1_entry_i,
    input  logic                                pop_i,
    output wb_entry_t                           head_o,
    output logic [CNT_W-1:0]                    count_o,
    output logic [DEPTH-1:0]                    entry_valid_o,
    output logic [DEPTH-1:0][ADDRESS_WIDTH-1:0] entry_wa_o
);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] slot1_ptr;
    wb_entry_t        slot_view [DEPTH];

    // The second push lands right after the first, or at wptr when only it fires.
    always_comb begin
        slot1_ptr = wptr_q + PTR_W'(push0_i);
        wptr_d    = wptr_q + PTR_W'(push0_i) + PTR_W'(push1_i);
        rptr_d    = rptr_q + PTR_W'(pop_i);
        count_d   = count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_i);
    end

    // Pointer and occupancy registers; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            wb_entry_t slot_q;
            logic      valid_q;
            logic      wr0, wr1, rd;

            assign wr0 = push0_i && (wptr_q == PTR_W'(gi));
            assign wr1 = push1_i && (slot1_ptr == PTR_W'(gi));
            assign rd  = pop_i && (rptr_q == PTR_W'(gi));

            // Slot payload; only written on a push targeting this slot.
            always_ff @(posedge clk) begin
                if (wr0) begin
                    slot_q <= push0_entry_i;
                end else if (wr1) begin
                    slot_q <= push1_entry_i;
                end
            end

            // Slot occupancy: set on push, cleared when the head leaves.
            always_ff @(posedge clk) begin
                if (!rst_ni) begin
                    valid_q <= 1'b0;
                end else if (wr0 || wr1) begin
                    valid_q <= 1'b1;
                end else if (rd) begin
                    valid_q <= 1'b0;
                end
            end

            assign slot_view[gi]     = slot_q;
            assign entry_valid_o[gi] = valid_q;
            assign entry_wa_o[gi]    = slot_q.wa;
        end
    endgenerate

    assign head_o  = slot_view[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/regfile_writer.sv
// Write-side front end of the integer register file: merges ALU and load
// results into one ordered queue, drives one registered write per cycle and
// publishes the set of destinations still in flight.
module regfile_writer #(
    parameter int DATA_WIDTH    = regfile_pkg::DATA_WIDTH,
    parameter int ADDRESS_WIDTH = regfile_pkg::ADDRESS_WIDTH,
    parameter int REGISTER_SIZE = 2 ** ADDRESS_WIDTH,
    parameter int FIFO_DEPTH    = regfile_pkg::FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDRESS_WIDTH-1:0] alu_wa,
    input  logic [DATA_WIDTH-1:0]    alu_wd,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDRESS_WIDTH-1:0] mem_wa,
    input  logic [DATA_WIDTH-1:0]    mem_wd,
    output logic                     RegWrite,
    output logic [ADDRESS_WIDTH-1:0] wa,
    output logic [DATA_WIDTH-1:0]    wd,
    output logic [REGISTER_SIZE-1:0] pending,
    output logic                     busy
);
    import regfile_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                                     push0, push1, pop;
    wb_entry_t                                alu_entry, mem_entry, head;
    logic [CNT_W-1:0]                         count;
    logic [FIFO_DEPTH-1:0]                    entry_valid;
    logic [FIFO_DEPTH-1:0][ADDRESS_WIDTH-1:0] entry_wa;
    logic                                     regwrite_q, regwrite_d;
    logic [ADDRESS_WIDTH-1:0]                 wa_q, wa_d;
    logic [DATA_WIDTH-1:0]                    wd_q, wd_d;
    logic [REGISTER_SIZE-1:0]                 pending_mask;

    // Readiness looks only at the registered count, so a same-cycle pop is
    // never credited and valid never loops back into ready.
    assign alu_ready = (count <= CNT_W'(FIFO_DEPTH - 1));
    assign mem_ready = (count <= CNT_W'(FIFO_DEPTH - 2));

    // Writes to x0 complete the handshake but are dropped here.
    assign push0     = alu_valid && alu_ready && (alu_wa != '0);
    assign push1     = mem_valid && mem_ready && (mem_wa != '0);
    assign alu_entry = '{wa: alu_wa, wd: alu_wd};
    assign mem_entry = '{wa: mem_wa, wd: mem_wd};
    assign pop       = (count != '0);

    wb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst_ni        (rst),
        .push0_i       (push0),
        .push0_entry_i (alu_entry),
        .push1_i       (push1),
        .push1_entry_i (mem_entry),
        .pop_i         (pop),
        .head_o        (head),
        .count_o       (count),
        .entry_valid_o (entry_valid),
        .entry_wa_o    (entry_wa)
    );

    // Issue the queue head every cycle it exists; address/data hold otherwise.
    always_comb begin
        regwrite_d = pop;
        wa_d       = wa_q;
        wd_d       = wd_q;
        if (pop) begin
            wa_d = head.wa;
            wd_d = head.wd;
        end
    end

    // Registered register-file write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            regwrite_q <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
        end
    end

    // Pending mask: every queued destination plus the one currently being written.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i]) begin
                pending_mask[entry_wa[i]] = 1'b1;
            end
        end
        if (regwrite_q) begin
            pending_mask[wa_q] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

    assign RegWrite = regwrite_q;
    assign wa       = wa_q;
    assign wd       = wd_q;
    assign pending  = pending_mask;
    assign busy     = (count != '0) || regwrite_q;

endmodule

// File: tb/tb_regfile_writer.sv
// Directed bench for regfile_writer: a cycle-by-cycle vector table followed by
// hand-written backpressure and mid-operation reset sequences.
module tb_regfile_writer;

    logic        clk;
    logic        rst;
    logic        alu_valid, mem_valid;
    logic        alu_ready, mem_ready;
    logic [4:0]  alu_wa, mem_wa;
    logic [63:0] alu_wd, mem_wd;
    logic        RegWrite;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [31:0] pending;
    logic        busy;

    int errors = 0;
    int checks = 0;

    regfile_writer dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_wa    (alu_wa),
        .alu_wd    (alu_wd),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_wa    (mem_wa),
        .mem_wd    (mem_wd),
        .RegWrite  (RegWrite),
        .wa        (wa),
        .wd        (wd),
        .pending   (pending),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  awa;
        logic [63:0] awd;
        logic        mv;
        logic [4:0]  mwa;
        logic [63:0] mwd;
        logic        e_rw;
        logic [4:0]  e_wa;
        logic [63:0] e_wd;
        logic [31:0] e_pend;
        logic        e_busy;
        logic        e_ar;
        logic        e_mr;
    } vec_t;

    typedef struct packed {
        logic [4:0]  wa;
        logic [63:0] wd;
    } ent_t;

    vec_t vecs[$];
    ent_t exp_q[$];

    function automatic vec_t mk(logic r, logic av, logic [4:0] awa, logic [63:0] awd,
                                logic mv, logic [4:0] mwa, logic [63:0] mwd,
                                logic rw, logic [4:0] ewa, logic [63:0] ewd,
                                logic [31:0] pend, logic bsy, logic ar, logic mr);
        vec_t v;
        v.rst = r;  v.av = av; v.awa = awa; v.awd = awd;
        v.mv = mv;  v.mwa = mwa; v.mwd = mwd;
        v.e_rw = rw; v.e_wa = ewa; v.e_wd = ewd; v.e_pend = pend;
        v.e_busy = bsy; v.e_ar = ar; v.e_mr = mr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic [4:0] awa, input logic [63:0] awd,
                         input logic mv, input logic [4:0] mwa, input logic [63:0] mwd);
        rst = r; alu_valid = av; alu_wa = awa; alu_wd = awd;
        mem_valid = mv; mem_wa = mwa; mem_wd = mwd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);

        // rst av awa awd        mv mwa mwd     | rw wa wd         pend         busy ar mr
        vecs.push_back(mk(0, 1, 5'd9,  64'h1,    1, 5'd10, 64'h2,  0, 5'd0,  64'h0,    32'h0,      0, 1, 1));
        vecs.push_back(mk(0, 1, 5'd9,  64'h1,    1, 5'd10, 64'h2,  0, 5'd0,  64'h0,    32'h0,      0, 1, 1));
        vecs.push_back(mk(1, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,  0, 5'd0,  64'h0,    32'h0,      0, 1, 1));
        vecs.push_back(mk(1, 1, 5'd5,  64'hDEAD, 0, 5'd0,  64'h0,  0, 5'd0,  64'h0,    32'h20,     1, 1, 1));
        vecs.push_back(mk(1, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,  1, 5'd5,  64'hDEAD, 32'h20,     1, 1, 1));
        vecs.push_back(mk(1, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,  0, 5'd5,  64'hDEAD, 32'h0,      0, 1, 1));
        vecs.push_back(mk(1, 1, 5'd3,  64'h11,   1, 5'd7,  64'h22, 0, 5'd5,  64'hDEAD, 32'h88,     1, 1, 1));
        vecs.push_back(mk(1, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,  1, 5'd3,  64'h11,   32'h88,     1, 1, 1));
        vecs.push_back(mk(1, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,  1, 5'd7,  64'h22,   32'h80,     1, 1, 1));
        vecs.push_back(mk(1, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,  0, 5'd7,  64'h22,   32'h0,      0, 1, 1));
        vecs.push_back(mk(1, 1, 5'd0,  64'hFF,   0, 5'd0,  64'h0,  0, 5'd7,  64'h22,   32'h0,      0, 1, 1));
        vecs.push_back(mk(1, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,  0, 5'd7,  64'h22,   32'h0,      0, 1, 1));
        vecs.push_back(mk(1, 1, 5'd12, 64'h44,   1, 5'd0,  64'h33, 0, 5'd7,  64'h22,   32'h1000,   1, 1, 1));
        vecs.push_back(mk(1, 1, 5'd12, 64'h55,   0, 5'd0,  64'h0,  1, 5'd12, 64'h44,   32'h1000,   1, 1, 1));
        vecs.push_back(mk(1, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,  1, 5'd12, 64'h55,   32'h1000,   1, 1, 1));
        vecs.push_back(mk(1, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,  0, 5'd12, 64'h55,   32'h0,      0, 1, 1));
        vecs.push_back(mk(1, 1, 5'd1,  64'hA,    1, 5'd2,  64'hB,  0, 5'd12, 64'h55,   32'h6,      1, 1, 1));
        vecs.push_back(mk(1, 1, 5'd4,  64'hC,    1, 5'd6,  64'hD,  1, 5'd1,  64'hA,    32'h56,     1, 1, 0));
        vecs.push_back(mk(1, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,  1, 5'd2,  64'hB,    32'h54,     1, 1, 1));
        vecs.push_back(mk(1, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,  1, 5'd4,  64'hC,    32'h50,     1, 1, 1));
        vecs.push_back(mk(1, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,  1, 5'd6,  64'hD,    32'h40,     1, 1, 1));
        vecs.push_back(mk(1, 0, 5'd0,  64'h0,    0, 5'd0,  64'h0,  0, 5'd6,  64'hD,    32'h0,      0, 1, 1));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].av, vecs[i].awa, vecs[i].awd,
                  vecs[i].mv, vecs[i].mwa, vecs[i].mwd);
            step();
            chk($sformatf("v%0d RegWrite", i), 64'(RegWrite), 64'(vecs[i].e_rw));
            chk($sformatf("v%0d wa", i), 64'(wa), 64'(vecs[i].e_wa));
            chk($sformatf("v%0d wd", i), wd, vecs[i].e_wd);
            chk($sformatf("v%0d pending", i), 64'(pending), 64'(vecs[i].e_pend));
            chk($sformatf("v%0d busy", i), 64'(busy), 64'(vecs[i].e_busy));
            chk($sformatf("v%0d alu_ready", i), 64'(alu_ready), 64'(vecs[i].e_ar));
            chk($sformatf("v%0d mem_ready", i), 64'(mem_ready), 64'(vecs[i].e_mr));
            $display("vec %0d: RegWrite=%0b wa=%0d wd=%0h pending=%08h busy=%0b", i, RegWrite, wa, wd, pending, busy);
        end

        // Backpressure: both producers always valid, x0 destinations mixed in.
        exp_q.delete();
        for (int k = 0; k < 40; k++) begin
            logic [4:0]  a_wa, m_wa;
            logic [63:0] a_wd, m_wd;
            logic        a_acc, m_acc, had;
            ent_t        e;
            a_wa = 5'((2 * k) % 8);
            m_wa = 5'((2 * k + 1) % 8);
            a_wd = 64'(1000 + 2 * k);
            m_wd = 64'(1001 + 2 * k);
            drive(1'b1, 1'b1, a_wa, a_wd, 1'b1, m_wa, m_wd);
            #1;
            a_acc = (exp_q.size() <= 3);
            m_acc = (exp_q.size() <= 2);
            chk($sformatf("bp%0d alu_ready", k), 64'(alu_ready), 64'(a_acc));
            chk($sformatf("bp%0d mem_ready", k), 64'(mem_ready), 64'(m_acc));
            @(posedge clk);
            #1;
            had = (exp_q.size() != 0);
            if (had) e = exp_q.pop_front();
            if (a_acc && a_wa != 5'd0) exp_q.push_back('{wa: a_wa, wd: a_wd});
            if (m_acc && m_wa != 5'd0) exp_q.push_back('{wa: m_wa, wd: m_wd});
            chk($sformatf("bp%0d RegWrite", k), 64'(RegWrite), 64'(had));
            if (had) begin
                chk($sformatf("bp%0d wa", k), 64'(wa), 64'(e.wa));
                chk($sformatf("bp%0d wd", k), wd, e.wd);
            end
            $display("bp %0d: acc=%0b%0b RegWrite=%0b wa=%0d wd=%0d", k, a_acc, m_acc, RegWrite, wa, wd);
        end
        drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        for (int c = 0; c < 8; c++) begin
            logic had;
            ent_t e;
            step();
            had = (exp_q.size() != 0);
            if (had) e = exp_q.pop_front();
            chk($sformatf("drain%0d RegWrite", c), 64'(RegWrite), 64'(had));
            if (had) begin
                chk($sformatf("drain%0d wa", c), 64'(wa), 64'(e.wa));
                chk($sformatf("drain%0d wd", c), wd, e.wd);
            end
            $display("drain %0d: RegWrite=%0b wa=%0d wd=%0d", c, RegWrite, wa, wd);
        end
        chk("drain leftover", 64'(exp_q.size()), 64'd0);
        chk("drain busy", 64'(busy), 64'd0);

        // Reset in the middle of activity: 3 entries queued and a write on the port.
        drive(1'b1, 1'b1, 5'd1, 64'h101, 1'b1, 5'd2, 64'h202);
        step();
        drive(1'b1, 1'b1, 5'd3, 64'h303, 1'b1, 5'd4, 64'h404);
        step();
        chk("mid RegWrite before rst", 64'(RegWrite), 64'd1);
        chk("mid pending before rst", 64'(pending), 64'h1E);
        drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        step();
        chk("mid RegWrite after rst", 64'(RegWrite), 64'd0);
        chk("mid pending after rst", 64'(pending), 64'd0);
        chk("mid busy after rst", 64'(busy), 64'd0);
        chk("mid mem_ready after rst", 64'(mem_ready), 64'd1);
        $display("mid rst: RegWrite=%0b pending=%08h busy=%0b", RegWrite, pending, busy);
        drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("post%0d RegWrite", c), 64'(RegWrite), 64'd0);
            chk($sformatf("post%0d pending", c), 64'(pending), 64'd0);
            $display("post rst %0d: RegWrite=%0b pending=%08h", c, RegWrite, pending);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
